lane_sink: RTL and testbench
============================

LANE_SINK -- requirements
Module: lane_sink

Interface
REQ-001 SHALL have parameter NLANES, default 3, meaning number of input lanes.
REQ-002 SHALL have parameter DW, default 8, meaning lane data width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning merge FIFO entries.
REQ-004 SHALL have parameter EXP, default {8'hFF,8'h00,8'hFF} (lane2,lane1,lane0), meaning expected value per lane.
REQ-005 SHALL have port i_clk, input, 1 bit: the block's only clock; all state changes on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_data, input, NLANES*DW bits: lane n occupies bits [n*DW +: DW].
REQ-008 SHALL have port i_valid, input, NLANES bits: per-lane data valid.
REQ-009 SHALL have port o_ready, output, NLANES bits: per-lane accept, at most one bit high.
REQ-010 SHALL have port o_data, output, DW bits: FIFO head data.
REQ-011 SHALL have port o_lane, output, 2 bits: FIFO head source lane.
REQ-012 SHALL have port o_valid, output, 1 bit: FIFO head valid.
REQ-013 SHALL have port i_ready, input, 1 bit: downstream accept.
REQ-014 SHALL have port o_level, output, 3 bits: FIFO occupancy, 0..DEPTH.
REQ-015 SHALL have port o_mismatch, output, NLANES bits: sticky per-lane expected-value error.
REQ-016 SHALL have port o_total, output, 16 bits: saturating count of accepted words.

Function
REQ-017 Grant SHALL be the first lane with i_valid high, searching from round-robin pointer rr upward with wrap NLANES-1 -> 0.
REQ-018 o_ready[grant] SHALL be high only when o_level < DEPTH and a grant exists; all other bits low; combinational from i_valid and registered state.
REQ-019 Push SHALL occur when i_valid[g] && o_ready[g]; {g, data} written to FIFO tail.
REQ-020 On push, rr SHALL become (g+1) mod NLANES; with no push, rr SHALL hold.
REQ-021 FIFO SHALL be first-word fall-through: o_valid = (o_level != 0); o_data/o_lane = head entry.
REQ-022 Push-to-o_valid latency SHALL be 1 cycle, including the empty case.
REQ-023 Pop SHALL occur when o_valid && i_ready; head advances next cycle.
REQ-024 Push and pop in the same cycle SHALL leave o_level unchanged.
REQ-025 When full, o_ready SHALL be all-zero even if a pop occurs that cycle; acceptance resumes the cycle after o_level drops.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; o_level SHALL never exceed DEPTH nor go below 0.
REQ-027 On push with data != EXP slice for lane g, o_mismatch[g] SHALL set the following cycle and hold until reset.
REQ-028 o_total SHALL increment by 1 per push and saturate at 16'hFFFF.
REQ-029 i_ready high with o_valid low SHALL have no effect.

Reset
REQ-030 While i_rst_n is low: o_ready = 0, o_valid = 0, o_level = 0, o_data = 0, o_lane = 0, o_mismatch = 0, o_total = 0, rr = 0, FIFO pointers = 0; all take effect immediately, without a clock edge.
REQ-031 Reset asserted mid-operation SHALL discard all FIFO contents; first push is allowed on the first rising edge after deassertion.

Verification
REQ-032 Reset check: 3 words queued, drop i_rst_n -> o_valid = 0, o_level = 0, o_total = 0, o_mismatch = 0 before the next edge.
REQ-033 Fill: all i_valid = 3'b111 with EXP data, i_ready = 0 -> o_ready sequence 001, 010, 100, 001, then 000; o_level = 4; o_mismatch = 0; o_total = 4.
REQ-034 Drain: from REQ-033 state, i_ready = 1 -> (o_lane, o_data) = (0,FF), (1,00), (2,FF), (0,FF); o_valid falls after the 4th pop.
REQ-035 Error: lane1 pushes 8'h5A -> o_mismatch = 3'b010 one cycle later; stays set after further good data.
REQ-036 Wrap: rr = 0, only i_valid[2] high -> o_ready = 3'b100; after push rr = 0; next grant with 3'b011 valid is lane0.
REQ-037 Full with pop: o_level = 4, i_ready = 1, all lanes valid -> o_ready = 0 that cycle; next cycle o_level = 3 and o_ready is one-hot.

Source files
------------

// File: rtl/lane_sink.sv
// Multi-lane merge sink: round-robin lane arbiter feeding a small FWFT FIFO,
// with per-lane sticky expected-value checking and a saturating word counter.
module lane_sink #(
  parameter int                   NLANES = 3,
  parameter int                   DW     = 8,
  parameter int                   DEPTH  = 4,
  parameter logic [NLANES*DW-1:0] EXP    = {8'hFF, 8'h00, 8'hFF}
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NLANES*DW-1:0] i_data,
  input  logic [NLANES-1:0]    i_valid,
  output logic [NLANES-1:0]    o_ready,
  output logic [DW-1:0]        o_data,
  output logic [1:0]           o_lane,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [2:0]           o_level,
  output logic [NLANES-1:0]    o_mismatch,
  output logic [15:0]          o_total
);

  localparam int LW  = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int LW1 = LW + 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW  = 2 + DW;

  logic [LW-1:0]     rr_q, rr_d;
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [2:0]        level_q, level_d;
  logic [NLANES-1:0] mism_q, mism_d;
  logic [15:0]       total_q, total_d;
  logic [EW-1:0]     mem_q [DEPTH];

  logic [LW-1:0]     gnt;
  logic              gnt_vld;
  logic [LW:0]       idx;
  logic [DW-1:0]     gdat;
  logic [DW-1:0]     gexp;
  logic [EW-1:0]     head;
  logic              full;
  logic              push;
  logic              pop;

  // First valid lane at or above rr, wrapping back to lane 0.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < NLANES; k++) begin
      idx = {1'b0, rr_q} + LW1'(k);
      if (idx >= LW1'(NLANES)) idx = idx - LW1'(NLANES);
      if (!gnt_vld && i_valid[idx[LW-1:0]]) begin
        gnt     = idx[LW-1:0];
        gnt_vld = 1'b1;
      end
    end
  end

  assign full    = (level_q == 3'(DEPTH));
  assign push    = gnt_vld && !full && i_rst_n;
  assign o_ready = push ? (NLANES'(1) << gnt) : '0;
  assign gdat    = i_data[int'(gnt)*DW +: DW];
  assign gexp    = EXP[int'(gnt)*DW +: DW];

  assign head    = mem_q[rd_q];
  assign o_valid = (level_q != 3'd0);
  assign pop     = o_valid && i_ready;
  assign o_data  = o_valid ? head[DW-1:0] : '0;
  assign o_lane  = o_valid ? head[EW-1 -: 2] : '0;
  assign o_level = level_q;
  assign o_mismatch = mism_q;
  assign o_total = total_q;

  always_comb begin
    rr_d    = rr_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    mism_d  = mism_q;
    total_d = total_q;
    if (push) begin
      rr_d = (gnt == LW'(NLANES - 1)) ? '0 : gnt + 1'b1;
      wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (gdat != gexp) mism_d = mism_q | (NLANES'(1) << gnt);
      if (total_q != 16'hFFFF) total_d = total_q + 16'd1;
    end
    if (pop) rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      mism_q  <= '0;
      total_q <= '0;
    end else begin
      rr_q    <= rr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      mism_q  <= mism_d;
      total_q <= total_d;
    end
  end

  // Storage needs no reset: o_valid masks whatever the array holds.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q] <= {2'(gnt), gdat};
  end

endmodule

// File: tb/tb_lane_sink.sv
// Bench for lane_sink: vector table with fixed expectations plus a
// reference model and scoreboard queue checked every cycle.
module tb_lane_sink;

  localparam logic [23:0] EXP_TB = 24'hFF00FF;
  localparam logic [23:0] G      = 24'hFF00FF;
  localparam logic [23:0] B      = 24'hFF5AFF;
  localparam logic [23:0] Z      = 24'h000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] i_data;
  logic [2:0]  i_valid;
  logic [2:0]  o_ready;
  logic [7:0]  o_data;
  logic [1:0]  o_lane;
  logic        o_valid;
  logic        i_ready;
  logic [2:0]  o_level;
  logic [2:0]  o_mismatch;
  logic [15:0] o_total;

  lane_sink dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_lane     (o_lane),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_level    (o_level),
    .o_mismatch (o_mismatch),
    .o_total    (o_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  v;
    logic [23:0] d;
    logic        r;
    logic [2:0]  erdy;
    logic [2:0]  elvl;
  } vec_t;

  vec_t        tbl[$];
  logic [9:0]  sbq[$];
  int          rr_m;
  logic [2:0]  mism_m;
  logic [15:0] tot_m;
  int          n_vec;
  int          n_err;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic add(input logic [2:0] v, input logic [23:0] d,
                     input logic r, input logic [2:0] erdy,
                     input logic [2:0] elvl);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.erdy = erdy; t.elvl = elvl;
    tbl.push_back(t);
  endtask

  task automatic model_reset();
    sbq.delete();
    rr_m   = 0;
    mism_m = '0;
    tot_m  = '0;
  endtask

  // Starts 1 time unit after a rising edge; ends at the same point one cycle on.
  task automatic cycle(input logic [2:0] v, input logic [23:0] d,
                       input logic r, input logic use_tbl,
                       input logic [2:0] erdy, input logic [2:0] elvl);
    logic [2:0] mr;
    int g;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    @(negedge clk);
    mr = '0;
    g  = -1;
    if (sbq.size() < 4)
      for (int k = 0; k < 3; k++)
        if (g < 0 && v[(rr_m + k) % 3]) g = (rr_m + k) % 3;
    if (g >= 0) mr[g] = 1'b1;
    if (use_tbl) begin
      chk("tbl_ready", o_ready, erdy);
      chk("tbl_level", o_level, elvl);
    end
    chk("ready", o_ready, mr);
    chk("level", o_level, sbq.size());
    chk("valid", o_valid, sbq.size() != 0);
    chk("mismatch", o_mismatch, mism_m);
    chk("total", o_total, tot_m);
    if (sbq.size() != 0) begin
      chk("head", {o_lane, o_data}, sbq[0]);
      if (r) void'(sbq.pop_front());
    end
    if (g >= 0) begin
      sbq.push_back({2'(g), d[g*8 +: 8]});
      if (d[g*8 +: 8] != EXP_TB[g*8 +: 8]) mism_m[g] = 1'b1;
      if (tot_m != 16'hFFFF) tot_m++;
      rr_m = (g + 1) % 3;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    i_valid = 3'b111;
    i_data  = G;
    i_ready = 1'b1;
    model_reset();

    #2;
    chk("rst_ready", o_ready, 3'b000);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_level", o_level, 3'd0);
    chk("rst_data", {o_lane, o_data}, 10'd0);
    chk("rst_total", o_total, 16'd0);
    i_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // fill, drain, wrap, error, full-with-pop
    add(3'b111, G, 1'b0, 3'b001, 3'd0);
    add(3'b111, G, 1'b0, 3'b010, 3'd1);
    add(3'b111, G, 1'b0, 3'b100, 3'd2);
    add(3'b111, G, 1'b0, 3'b001, 3'd3);
    add(3'b111, G, 1'b0, 3'b000, 3'd4);
    add(3'b000, Z, 1'b1, 3'b000, 3'd4);
    add(3'b000, Z, 1'b1, 3'b000, 3'd3);
    add(3'b000, Z, 1'b1, 3'b000, 3'd2);
    add(3'b000, Z, 1'b1, 3'b000, 3'd1);
    add(3'b000, Z, 1'b1, 3'b000, 3'd0);
    add(3'b100, G, 1'b0, 3'b100, 3'd0);
    add(3'b011, G, 1'b0, 3'b001, 3'd1);
    add(3'b000, Z, 1'b1, 3'b000, 3'd2);
    add(3'b000, Z, 1'b1, 3'b000, 3'd1);
    add(3'b000, Z, 1'b1, 3'b000, 3'd0);
    add(3'b010, B, 1'b1, 3'b010, 3'd0);
    add(3'b010, G, 1'b1, 3'b010, 3'd1);
    add(3'b000, Z, 1'b1, 3'b000, 3'd1);
    add(3'b000, Z, 1'b1, 3'b000, 3'd0);
    add(3'b111, G, 1'b0, 3'b100, 3'd0);
    add(3'b111, G, 1'b0, 3'b001, 3'd1);
    add(3'b111, G, 1'b0, 3'b010, 3'd2);
    add(3'b111, G, 1'b0, 3'b100, 3'd3);
    add(3'b111, G, 1'b0, 3'b000, 3'd4);
    add(3'b111, G, 1'b1, 3'b000, 3'd4);
    add(3'b111, G, 1'b0, 3'b001, 3'd3);

    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r, 1'b1, tbl[i].erdy, tbl[i].elvl);
      if (i == 4) chk("fill_total", o_total, 16'd4);
      if (i == 18) chk("mism_sticky", o_mismatch, 3'b010);
    end

    for (int i = 0; i < 5; i++) cycle(3'b000, Z, 1'b1, 1'b0, '0, '0);
    chk("drained", o_level, 3'd0);

    // long run through the counter saturation point
    for (int i = 0; i < 65600; i++) cycle(3'b001, G, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 2; i++) cycle(3'b000, Z, 1'b1, 1'b0, '0, '0);
    chk("total_sat", o_total, 16'hFFFF);

    for (int i = 0; i < 3; i++) cycle(3'b001, G, 1'b0, 1'b0, '0, '0);
    chk("pre_rst_level", o_level, 3'd3);
    i_valid = 3'b111;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", o_valid, 1'b0);
    chk("arst_level", o_level, 3'd0);
    chk("arst_total", o_total, 16'd0);
    chk("arst_mism", o_mismatch, 3'b000);
    chk("arst_ready", o_ready, 3'b000);
    @(posedge clk);
    #1;
    chk("held_level", o_level, 3'd0);
    rst_n = 1'b1;
    cycle(3'b010, G, 1'b0, 1'b1, 3'b010, 3'd0);
    cycle(3'b000, Z, 1'b1, 1'b1, 3'b000, 3'd1);
    cycle(3'b000, Z, 1'b1, 1'b1, 3'b000, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
